// File: rtl/seg7_scan_disp.sv
// Multiplexed 7-segment display driver. Display contents change only at
// frame boundaries. Supports rotated glyphs, leading-zero blanking and per-digit blink.
module seg7_scan_disp #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr,
  input  logic [4*NUM_DIGITS-1:0]   i_data,
  input  logic [NUM_DIGITS-1:0]     i_rot_mask,
  input  logic [NUM_DIGITS-1:0]     i_blink_mask,
  input  logic                      i_blank_lz,
  output logic                      o_ready,
  output logic [6:0]                o_seg,
  output logic [NUM_DIGITS-1:0]     o_dig,
  output logic                      o_frame
);
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h67;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Upside-down glyph: a<->d, b<->e, c<->f, g unchanged.
  function automatic logic [6:0] rotate_seg(input logic [6:0] s);
    return {s[6], s[2:0], s[5:3]};
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic                    blk_ph_q, blk_ph_d;
  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   pend_rot_q, pend_rot_d, disp_rot_q, disp_rot_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, disp_blink_q, disp_blink_d;
  logic                    pend_blz_q, pend_blz_d, disp_blz_q, disp_blz_d;
  logic                    ready_q, ready_d, frame_q, frame_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;

  logic                    tick_s, boundary_s, nz_above_s, blank_s;
  logic [3:0]              nib_s;
  logic [6:0]              lit_s;
  logic [NUM_DIGITS-1:0]   onehot_s;

  // Next-state logic: scan timing, blink phase, write handshake and glyph decode.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    blk_cnt_d    = blk_cnt_q;
    blk_ph_d     = blk_ph_q;
    state_d      = state_q;
    pend_data_d  = pend_data_q;
    pend_rot_d   = pend_rot_q;
    pend_blink_d = pend_blink_q;
    pend_blz_d   = pend_blz_q;
    disp_data_d  = disp_data_q;
    disp_rot_d   = disp_rot_q;
    disp_blink_d = disp_blink_q;
    disp_blz_d   = disp_blz_q;

    tick_s     = (cnt_q == CNT_MAX);
    boundary_s = tick_s && (idx_q == IDX_MAX);

    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = (idx_q == IDX_MAX) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end

    if (boundary_s) begin
      if (blk_cnt_q == BLK_MAX) begin
        blk_cnt_d = {BLK_W{1'b0}};
        blk_ph_d  = ~blk_ph_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
        blk_ph_d  = blk_ph_q;
      end
    end else begin
      blk_cnt_d = blk_cnt_q;
      blk_ph_d  = blk_ph_q;
    end

    // Commit only from PEND, so a write landing on a boundary waits a full frame.
    case (state_q)
      ST_IDLE: begin
        if (i_wr) begin
          pend_data_d  = i_data;
          pend_rot_d   = i_rot_mask;
          pend_blink_d = i_blink_mask;
          pend_blz_d   = i_blank_lz;
          state_d      = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (boundary_s) begin
          disp_data_d  = pend_data_q;
          disp_rot_d   = pend_rot_q;
          disp_blink_d = pend_blink_q;
          disp_blz_d   = pend_blz_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    frame_d = boundary_s;

    nib_s      = disp_data_q[{idx_q, 2'b00} +: 4];
    nz_above_s = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      nz_above_s = nz_above_s | ((j > int'(idx_q)) && (disp_data_q[4*j +: 4] != 4'h0));
    end
    blank_s = (disp_blz_q && (nib_s == 4'h0) && (idx_q != {IDX_W{1'b0}}) && !nz_above_s)
            || (blk_ph_q && disp_blink_q[idx_q]);

    if (blank_s) begin
      lit_s = 7'h00;
    end else if (disp_rot_q[idx_q]) begin
      lit_s = rotate_seg(hex_to_seg(nib_s));
    end else begin
      lit_s = hex_to_seg(nib_s);
    end

    onehot_s = NUM_DIGITS'(1) << idx_q;
    seg_d    = ACTIVE_LOW ? ~lit_s : lit_s;
    dig_d    = ACTIVE_LOW ? ~onehot_s : onehot_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      blk_cnt_q    <= {BLK_W{1'b0}};
      blk_ph_q     <= 1'b0;
      state_q      <= ST_IDLE;
      pend_data_q  <= {(4*NUM_DIGITS){1'b0}};
      pend_rot_q   <= {NUM_DIGITS{1'b0}};
      pend_blink_q <= {NUM_DIGITS{1'b0}};
      pend_blz_q   <= 1'b0;
      disp_data_q  <= {(4*NUM_DIGITS){1'b0}};
      disp_rot_q   <= {NUM_DIGITS{1'b0}};
      disp_blink_q <= {NUM_DIGITS{1'b0}};
      disp_blz_q   <= 1'b0;
      ready_q      <= 1'b1;
      frame_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_ph_q     <= blk_ph_d;
      state_q      <= state_d;
      pend_data_q  <= pend_data_d;
      pend_rot_q   <= pend_rot_d;
      pend_blink_q <= pend_blink_d;
      pend_blz_q   <= pend_blz_d;
      disp_data_q  <= disp_data_d;
      disp_rot_q   <= disp_rot_d;
      disp_blink_q <= disp_blink_d;
      disp_blz_q   <= disp_blz_d;
      ready_q      <= ready_d;
      frame_q      <= frame_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign o_ready = ready_q;
  assign o_frame = frame_q;
  assign o_seg   = seg_q;
  assign o_dig   = dig_q;
endmodule

// File: tb/tb_seg7_scan_disp.sv
// Self-checking bench for seg7_scan_disp: per-cycle scoreboard against a
// time-based reference model, table-driven glyph checks and corner sequences.
module tb_seg7_scan_disp;
  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BF = 2;
  localparam int FR = CD * ND;

  logic        clk = 1'b0;
  logic        rst, wr, blz;
  logic [15:0] data;
  logic [3:0]  rot, blink;
  logic        ready, frame;
  logic [6:0]  seg;
  logic [3:0]  dig;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_disp #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(data), .i_rot_mask(rot),
    .i_blink_mask(blink), .i_blank_lz(blz), .o_ready(ready), .o_seg(seg),
    .o_dig(dig), .o_frame(frame)
  );

  string SEGS[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                      "abcdefg", "abcfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  // Reference model: cycle count since reset plus displayed/pending values.
  int m_t = 0;
  bit m_pend = 0;
  int p_data = 0, p_rot = 0, p_blink = 0, p_blz = 0;
  int m_data = 0, m_rot = 0, m_blink = 0, m_blz = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  r;
    logic [3:0]  b;
    logic        z;
    int          digit;
    logic [6:0]  exp_seg;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_lit(int nib, bit r);
    logic [6:0] m;
    m = 7'h00;
    for (int i = 0; i < SEGS[nib].len(); i++) begin
      int s;
      s = int'(SEGS[nib].getc(i)) - 97;
      if (r && s < 6) s = (s + 3) % 6;
      m[s] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [6:0] ref_seg(int k, int ph);
    int  nib;
    bit  blank;
    nib   = (m_data >> (4 * k)) & 15;
    blank = (m_blz != 0 && nib == 0 && k > 0 && (m_data >> (4 * (k + 1))) == 0)
         || (ph == 1 && ((m_blink >> k) & 1) == 1);
    return blank ? 7'h7F : ~ref_lit(nib, ((m_rot >> k) & 1) == 1);
  endfunction

  // One clock: predict post-edge outputs, advance model, compare at negedge.
  task automatic step();
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    logic       e_frame, e_ready;
    int idx, ph;
    if (rst) begin
      m_t = 0; m_pend = 0;
      p_data = 0; p_rot = 0; p_blink = 0; p_blz = 0;
      m_data = 0; m_rot = 0; m_blink = 0; m_blz = 0;
      e_seg = 7'h7F; e_dig = 4'hF; e_frame = 1'b0; e_ready = 1'b1;
    end else begin
      idx     = (m_t / CD) % ND;
      ph      = ((m_t / FR) / BF) % 2;
      e_seg   = ref_seg(idx, ph);
      e_dig   = ~(4'b0001 << idx);
      e_frame = ((m_t % FR) == FR - 1);
      if (m_pend) begin
        if (e_frame) begin
          m_data = p_data; m_rot = p_rot; m_blink = p_blink; m_blz = p_blz;
          m_pend = 0;
        end
      end else if (wr) begin
        p_data = int'(data); p_rot = int'(rot); p_blink = int'(blink); p_blz = int'(blz);
        m_pend = 1;
      end
      e_ready = !m_pend;
      m_t++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("seg", seg, e_seg);
    chk("dig", dig, e_dig);
    chk("frame", frame, e_frame);
    chk("ready", ready, e_ready);
  endtask

  task automatic do_write(input logic [15:0] d, input logic [3:0] r, input logic [3:0] b, input logic z);
    int n = 0;
    while (ready !== 1'b1 && n < 64) begin step(); n++; end
    chk("ready_before_write", ready, 1'b1);
    data = d; rot = r; blink = b; blz = z; wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic wait_commit();
    int n = 0;
    while (ready !== 1'b1 && n < 64) begin step(); n++; end
    chk("commit_ready", ready, 1'b1);
    step();
  endtask

  task automatic check_digit(input string name, input int k, input logic [6:0] exp);
    logic [3:0] oh, target;
    int n = 0;
    oh = 4'b0001 << k;
    target = ~oh;
    while (dig !== target && n < 32) begin step(); n++; end
    chk({name, "_dig"}, dig, target);
    chk({name, "_seg"}, seg, exp);
  endtask

  task automatic align(input int ph);
    int n = 0;
    while ((m_t % FR) != ph && n < 2 * FR) begin step(); n++; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] seq[8];
    int n_lit, n_blank, n_run3, n0;

    rst = 1'b1; wr = 1'b0; data = 16'h0000; rot = 4'h0; blink = 4'h0; blz = 1'b0;

    vecs.push_back('{16'h12AF, 4'h0, 4'h0, 1'b0, 0, 7'b0001110});
    vecs.push_back('{16'h12AF, 4'h0, 4'h0, 1'b0, 1, 7'b0001000});
    vecs.push_back('{16'h12AF, 4'h0, 4'h0, 1'b0, 2, 7'b0100100});
    vecs.push_back('{16'h12AF, 4'h0, 4'h0, 1'b0, 3, 7'b1111001});
    vecs.push_back('{16'h0005, 4'h0, 4'h0, 1'b1, 3, 7'b1111111});
    vecs.push_back('{16'h0005, 4'h0, 4'h0, 1'b1, 2, 7'b1111111});
    vecs.push_back('{16'h0005, 4'h0, 4'h0, 1'b1, 1, 7'b1111111});
    vecs.push_back('{16'h0005, 4'h0, 4'h0, 1'b1, 0, 7'b0010010});
    vecs.push_back('{16'h0000, 4'h0, 4'h0, 1'b1, 0, 7'b1000000});
    vecs.push_back('{16'h0000, 4'h0, 4'h0, 1'b1, 1, 7'b1111111});
    vecs.push_back('{16'h0100, 4'h0, 4'h0, 1'b1, 1, 7'b1000000});
    vecs.push_back('{16'h0100, 4'h0, 4'h0, 1'b1, 3, 7'b1111111});
    vecs.push_back('{16'h0001, 4'h1, 4'h0, 1'b0, 0, 7'b1001111});
    vecs.push_back('{16'h0001, 4'h0, 4'h0, 1'b0, 0, 7'b1111001});
    vecs.push_back('{16'h8888, 4'h0, 4'h2, 1'b0, 0, 7'b0000000});
    vecs.push_back('{16'h8888, 4'h0, 4'h2, 1'b0, 2, 7'b0000000});

    step(); step();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      do_write(vecs[i].d, vecs[i].r, vecs[i].b, vecs[i].z);
      wait_commit();
      check_digit($sformatf("vec%0d", i), vecs[i].digit, vecs[i].exp_seg);
    end

    // Blink: digit 1 alternates two lit frames and two blank frames.
    do_write(16'h8888, 4'h0, 4'h2, 1'b0);
    wait_commit();
    for (int f = 0; f < 8; f++) begin
      seq[f] = 7'h55;
      for (int c = 0; c < FR; c++) begin
        step();
        if (dig === 4'b1101) seq[f] = seg;
      end
    end
    n_lit = 0; n_blank = 0; n_run3 = 0;
    for (int f = 0; f < 8; f++) begin
      if (seq[f] === 7'b0000000) n_lit++;
      if (seq[f] === 7'b1111111) n_blank++;
    end
    for (int f = 0; f < 6; f++)
      if (seq[f] === seq[f+1] && seq[f+1] === seq[f+2]) n_run3++;
    chk("blink_lit_frames", n_lit, 4);
    chk("blink_blank_frames", n_blank, 4);
    chk("blink_runs_of_3", n_run3, 0);

    // Write while pending is ignored.
    align(2);
    do_write(16'h1111, 4'h0, 4'h0, 1'b0);
    data = 16'h2222; wr = 1'b1;
    repeat (3) step();
    wr = 1'b0;
    wait_commit();
    check_digit("ignored_wr", 0, 7'b1111001);

    // Write on the boundary cycle commits one frame later.
    align(FR - 1);
    data = 16'h3333; rot = 4'h0; blink = 4'h0; blz = 1'b0; wr = 1'b1;
    step();
    wr = 1'b0;
    chk("coinc_ready_low", ready, 1'b0);
    step();
    chk("coinc_old_dig", dig, 4'b1110);
    chk("coinc_old_seg", seg, 7'b1111001);
    wait_commit();
    check_digit("coinc_new", 0, 7'b0110000);

    // Reset while pending discards the pending value.
    align(3);
    do_write(16'h8888, 4'h0, 4'h0, 1'b0);
    step();
    chk("pend_before_rst", ready, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_ready", ready, 1'b1);
    chk("rst_dig", dig, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    rst = 1'b0;
    n0 = 0;
    repeat (40) begin
      step();
      if (seg === 7'b0000000) n0++;
    end
    chk("rst_discard", n0, 0);

    // Randomized traffic checked cycle by cycle by the scoreboard.
    repeat (600) begin
      wr    = ($urandom_range(0, 3) == 0);
      data  = 16'($urandom);
      rot   = 4'($urandom);
      blink = 4'($urandom);
      blz   = 1'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; wr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
